// File: rtl/jesd204_rx_link_sequencer_if.sv
// Bundle of the sequencer's link-side signals: PHY/LMFC status, lane
// configuration, per-lane handshakes and the sequencer's controls/status.
// The sequencer connects through the master modport; lanes, PHY glue and
// status consumers connect through the slave modport.
interface jesd204_rx_link_sequencer_if #(
    parameter int NUM_LANES = 1
);
    logic                 phy_ready;
    logic                 lmfc_edge;
    logic [NUM_LANES-1:0] cfg_lanes_disable;
    logic [NUM_LANES-1:0] lane_cgs_ready;
    logic [NUM_LANES-1:0] lane_buffer_ready_n;
    logic [NUM_LANES-1:0] cgs_reset;
    logic [NUM_LANES-1:0] ifs_reset;
    logic                 buffer_release_n;
    logic                 sync_n;
    logic [2:0]           status_state;
    logic [7:0]           status_restart_cnt;

    modport master (
        input  phy_ready,
        input  lmfc_edge,
        input  cfg_lanes_disable,
        input  lane_cgs_ready,
        input  lane_buffer_ready_n,
        output cgs_reset,
        output ifs_reset,
        output buffer_release_n,
        output sync_n,
        output status_state,
        output status_restart_cnt
    );

    modport slave (
        output phy_ready,
        output lmfc_edge,
        output cfg_lanes_disable,
        output lane_cgs_ready,
        output lane_buffer_ready_n,
        input  cgs_reset,
        input  ifs_reset,
        input  buffer_release_n,
        input  sync_n,
        input  status_state,
        input  status_restart_cnt
    );
endinterface

// File: rtl/jesd204_rx_link_sequencer.sv
// JESD204 RX link bring-up sequencer: waits for the PHY, runs code-group
// synchronisation on the enabled lanes, deglitches the all-lanes-ready
// condition, aligns SYNC~ release to an LMFC boundary and then releases the
// elastic buffers on the first LMFC edge where every enabled lane is ready.
// Optional feature: define JESD204_RX_SEQ_TIMEOUT_EN to restart the link
// after 65535 cycles spent in CGS/DEGLITCH without reaching SYNCHRONIZED.
module jesd204_rx_link_sequencer #(
    parameter int NUM_LANES       = 1,
    parameter int DEGLITCH_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    jesd204_rx_link_sequencer_if.master  seq
);

    typedef enum logic [2:0] {
        StReset    = 3'd0,
        StWaitPhy  = 3'd1,
        StCgs      = 3'd2,
        StDeglitch = 3'd3,
        StSync     = 3'd4
    } state_e;

    localparam logic [7:0] DgLast = 8'(DEGLITCH_CYCLES - 1);

    state_e               state_q, state_d;
    // Cleared by reset and set on the first edge, so the RESET state is held
    // across the first edge after reset release.
    logic                 armed_q;
    logic [7:0]           dg_cnt_q, dg_cnt_d;
    logic [7:0]           restart_q, restart_d;
    logic                 restart_inc;
    logic [NUM_LANES-1:0] cfg_q;

    logic [NUM_LANES-1:0] cgs_reset_q, cgs_reset_d;
    logic [NUM_LANES-1:0] ifs_reset_q, ifs_reset_d;
    logic                 sync_n_q, sync_n_d;
    logic                 release_n_q, release_n_d;

    logic [NUM_LANES-1:0] lane_en;
    logic                 any_lane_en;
    logic                 cgs_all_ready;
    logic                 cgs_lost;
    logic                 buf_all_ready;
    logic                 cfg_changed;
    logic                 timeout_hit;

    // Lane qualification: disabled lanes never block and never cause loss.
    always_comb begin
        lane_en       = ~seq.cfg_lanes_disable;
        any_lane_en   = |lane_en;
        cgs_lost      = |(lane_en & ~seq.lane_cgs_ready);
        cgs_all_ready = ~cgs_lost;
        buf_all_ready = ~|(lane_en & seq.lane_buffer_ready_n);
        cfg_changed   = (seq.cfg_lanes_disable != cfg_q);
    end

`ifdef JESD204_RX_SEQ_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;

    // Timeout counter: cycles spent so far in CGS/DEGLITCH since entering CGS.
    always_comb begin
        tmo_d       = 16'd0;
        timeout_hit = 1'b0;
        if (state_q == StCgs || state_q == StDeglitch) begin
            timeout_hit = (tmo_q == 16'hFFFE);
            if (state_d == StCgs || state_d == StDeglitch) begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= 16'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    // No timeout: CGS/DEGLITCH wait indefinitely.
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    // Next-state logic. PHY loss beats everything, then a configuration
    // change, then a timeout, then the per-state rules.
    always_comb begin
        state_d     = state_q;
        restart_inc = 1'b0;
        if (state_q == StReset) begin
            if (armed_q) begin
                state_d = StWaitPhy;
            end
        end else if (!seq.phy_ready) begin
            state_d = StReset;
        end else if (state_q != StWaitPhy && cfg_changed) begin
            state_d = StReset;
        end else if (timeout_hit) begin
            state_d     = StReset;
            restart_inc = 1'b1;
        end else begin
            case (state_q)
                StWaitPhy: begin
                    if (any_lane_en) begin
                        state_d = StCgs;
                    end
                end
                StCgs: begin
                    if (cgs_all_ready) begin
                        state_d = StDeglitch;
                    end
                end
                StDeglitch: begin
                    if (cgs_lost) begin
                        state_d = StCgs;
                    end else if (dg_cnt_q == DgLast && seq.lmfc_edge) begin
                        state_d = StSync;
                    end
                end
                StSync: begin
                    if (cgs_lost) begin
                        state_d     = StReset;
                        restart_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = StReset;
                end
            endcase
        end
    end

    // Deglitch count and saturating restart count.
    always_comb begin
        dg_cnt_d = 8'd0;
        if (state_q == StDeglitch && state_d == StDeglitch) begin
            dg_cnt_d = (dg_cnt_q == DgLast) ? dg_cnt_q : dg_cnt_q + 8'd1;
        end
        restart_d = restart_q;
        if (restart_inc && restart_q != 8'hFF) begin
            restart_d = restart_q + 8'd1;
        end
    end

    // Output next values, derived from the next state so they line up with
    // status_state; disabled lanes stay in reset throughout.
    always_comb begin
        cgs_reset_d = '1;
        ifs_reset_d = '1;
        sync_n_d    = 1'b0;
        release_n_d = 1'b1;
        if (state_d == StCgs || state_d == StDeglitch || state_d == StSync) begin
            cgs_reset_d = seq.cfg_lanes_disable;
        end
        if (state_d == StSync) begin
            ifs_reset_d = seq.cfg_lanes_disable;
            sync_n_d    = 1'b1;
            // Release latches low on the first qualifying LMFC edge seen
            // while already synchronized.
            release_n_d = release_n_q &
                          ~((state_q == StSync) & seq.lmfc_edge & buf_all_ready);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StReset;
            armed_q     <= 1'b0;
            dg_cnt_q    <= 8'd0;
            restart_q   <= 8'd0;
            cfg_q       <= '0;
            cgs_reset_q <= '1;
            ifs_reset_q <= '1;
            sync_n_q    <= 1'b0;
            release_n_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            armed_q     <= 1'b1;
            dg_cnt_q    <= dg_cnt_d;
            restart_q   <= restart_d;
            cfg_q       <= seq.cfg_lanes_disable;
            cgs_reset_q <= cgs_reset_d;
            ifs_reset_q <= ifs_reset_d;
            sync_n_q    <= sync_n_d;
            release_n_q <= release_n_d;
        end
    end

    // Drive the interface from the registered values.
    always_comb begin
        seq.cgs_reset          = cgs_reset_q;
        seq.ifs_reset          = ifs_reset_q;
        seq.sync_n             = sync_n_q;
        seq.buffer_release_n   = release_n_q;
        seq.status_state       = state_q;
        seq.status_restart_cnt = restart_q;
    end

endmodule

// File: tb/tb_jesd204_rx_link_sequencer.sv
// Bench for jesd204_rx_link_sequencer (4 lanes, 16-cycle deglitch).
// Directed bring-up scenarios plus a randomized soak, every cycle compared
// against a reference model of the link rules kept here.
module tb_jesd204_rx_link_sequencer;

    localparam int NL = 4;
    localparam int DG = 16;
    localparam int MReset = 0, MWaitPhy = 1, MCgs = 2, MDeglitch = 3, MSync = 4;
`ifdef JESD204_RX_SEQ_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lmfc_per = 8;

    jesd204_rx_link_sequencer_if #(.NUM_LANES(NL)) bus ();

    jesd204_rx_link_sequencer #(
        .NUM_LANES      (NL),
        .DEGLITCH_CYCLES(DG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .seq  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    int          m_state, m_cnt, m_rc, m_tmo;
    bit          m_armed, m_rel;
    logic [3:0]  m_cfg_prev, m_cfg_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = MReset; m_cnt = 0; m_rc = 0; m_tmo = 0;
        m_armed = 0; m_rel = 1; m_cfg_prev = 4'h0; m_cfg_seen = 4'h0;
    endtask

    // One clock edge of the link rules, evaluated on the inputs at that edge.
    task automatic model_step();
        logic [3:0] en;
        bit lost, bufok, chg, inc;
        int nxt;
        en    = ~bus.cfg_lanes_disable;
        lost  = |(en & ~bus.lane_cgs_ready);
        bufok = ((en & bus.lane_buffer_ready_n) == 4'h0);
        chg   = (bus.cfg_lanes_disable != m_cfg_prev);
        nxt   = m_state;
        inc   = 0;
        if (m_state == MReset) begin
            if (m_armed) nxt = MWaitPhy;
        end else if (!bus.phy_ready) begin
            nxt = MReset;
        end else if (m_state != MWaitPhy && chg) begin
            nxt = MReset;
        end else if (TMO && (m_state == MCgs || m_state == MDeglitch) && m_tmo == 65534) begin
            nxt = MReset; inc = 1;
        end else if (m_state == MWaitPhy) begin
            if (en != 0) nxt = MCgs;
        end else if (m_state == MCgs) begin
            if (!lost) nxt = MDeglitch;
        end else if (m_state == MDeglitch) begin
            if (lost) nxt = MCgs;
            else if (m_cnt == DG - 1 && bus.lmfc_edge) nxt = MSync;
        end else if (m_state == MSync) begin
            if (lost) begin nxt = MReset; inc = 1; end
        end
        m_cnt = (m_state == MDeglitch && nxt == MDeglitch) ? ((m_cnt < DG - 1) ? m_cnt + 1 : m_cnt) : 0;
        m_tmo = ((m_state == MCgs || m_state == MDeglitch) && (nxt == MCgs || nxt == MDeglitch))
                ? m_tmo + 1 : 0;
        m_rel = (nxt == MSync) ? (m_rel && !(m_state == MSync && bus.lmfc_edge && bufok)) : 1'b1;
        if (inc && m_rc < 255) m_rc++;
        m_armed    = 1;
        m_cfg_prev = bus.cfg_lanes_disable;
        m_cfg_seen = bus.cfg_lanes_disable;
        m_state    = nxt;
    endtask

    task automatic compare_all();
        chk("state", 32'(bus.status_state), 32'(m_state));
        chk("cgs_reset", 32'(bus.cgs_reset), (m_state >= MCgs) ? 32'(m_cfg_seen) : 32'hF);
        chk("ifs_reset", 32'(bus.ifs_reset), (m_state == MSync) ? 32'(m_cfg_seen) : 32'hF);
        chk("sync_n", 32'(bus.sync_n), (m_state == MSync) ? 32'd1 : 32'd0);
        chk("buffer_release_n", 32'(bus.buffer_release_n), 32'(m_rel));
        chk("restart_cnt", 32'(bus.status_restart_cnt), 32'(m_rc));
    endtask

    // Advance one clock; inputs may be changed by the caller afterwards.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        cyc++;
        bus.lmfc_edge = (cyc % lmfc_per) == 0;
    endtask

    task automatic run_until(input int target, input int bound, input string tag);
        int n = 0;
        while (m_state != target && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.status_state), 32'(target));
    endtask

    int dg_len, entries, n;
    logic [3:0] r;

    initial begin
        reset = 1'b1;
        bus.phy_ready = 1'b0;
        bus.lmfc_edge = 1'b0;
        bus.cfg_lanes_disable = 4'h0;
        bus.lane_cgs_ready = 4'h0;
        bus.lane_buffer_ready_n = 4'hF;
        lmfc_per = 4 + int'($urandom_range(0, 8));
        model_reset();
        #3;
        compare_all();
        #9 reset = 1'b0;

        // First edge after release holds RESET; second moves on.
        tick();
        chk("hold_first_edge", 32'(bus.status_state), 32'(MReset));
        bus.phy_ready = 1'b1;
        tick();
        chk("second_edge_wait_phy", 32'(bus.status_state), 32'(MWaitPhy));

        // All four lanes ready together: at least 16 DEGLITCH cycles, then sync.
        bus.lane_cgs_ready = 4'hF;
        dg_len = 0;
        n = 0;
        while (m_state != MSync && n < 200) begin
            tick();
            if (bus.status_state == 3'd3) dg_len++;
            n++;
        end
        chk("sync_reached", 32'(bus.status_state), 32'(MSync));
        chk("deglitch_min_16", 32'(dg_len >= DG), 32'd1);
        chk("ifs_reset_all_zero", 32'(bus.ifs_reset), 32'h0);
        chk("sync_n_high", 32'(bus.sync_n), 32'd1);

        // Lane 2 drops at deglitch cycle 5: back to CGS, full count again.
        bus.phy_ready = 1'b0;
        tick();
        bus.phy_ready = 1'b1;
        run_until(MDeglitch, 50, "reenter_deglitch");
        repeat (4) tick();
        bus.lane_cgs_ready = 4'b1011;
        tick();
        chk("lane2_drop_to_cgs", 32'(bus.status_state), 32'(MCgs));
        bus.lane_cgs_ready = 4'hF;
        dg_len = 0;
        n = 0;
        while (m_state != MSync && n < 200) begin
            tick();
            if (bus.status_state == 3'd3) dg_len++;
            n++;
        end
        chk("resync_after_drop", 32'(bus.status_state), 32'(MSync));
        chk("deglitch_restart_16", 32'(dg_len >= DG), 32'd1);

        // Buffers become ready between LMFC edges: release waits for the next edge.
        n = 0;
        while (!bus.lmfc_edge && n < 64) begin tick(); n++; end
        tick();
        bus.lane_buffer_ready_n = 4'h0;
        n = 0;
        while (!bus.lmfc_edge && n < 64) begin
            tick();
            chk("release_not_early", 32'(bus.buffer_release_n), 32'd1);
            n++;
        end
        tick();
        chk("release_after_lmfc", 32'(bus.buffer_release_n), 32'd0);

        // Lane 3 disabled and never ready: link still synchronizes.
        bus.cfg_lanes_disable = 4'b1000;
        bus.lane_cgs_ready = 4'b0111;
        tick();
        chk("cfg_change_resets", 32'(bus.status_state), 32'(MReset));
        run_until(MSync, 300, "sync_lane3_disabled");
        chk("cgs_reset3", 32'(bus.cgs_reset[3]), 32'd1);
        chk("ifs_reset3", 32'(bus.ifs_reset[3]), 32'd1);
        chk("ifs_reset_mask", 32'(bus.ifs_reset), 32'h8);

        // 300 single-cycle losses on lane 0: restart count saturates at 255.
        bus.cfg_lanes_disable = 4'h0;
        bus.lane_cgs_ready = 4'hF;
        run_until(MSync, 300, "sync_all_lanes");
        entries = 0;
        for (int i = 0; i < 300; i++) begin
            bus.lane_cgs_ready = 4'b1110;
            tick();
            if (bus.status_state == 3'd0) entries++;
            bus.lane_cgs_ready = 4'hF;
            run_until(MSync, 200, "resync_loop");
        end
        chk("reset_entries_300", 32'(entries), 32'd300);
        chk("restart_saturated", 32'(bus.status_restart_cnt), 32'd255);

        // Randomized soak with one mid-operation asynchronous reset.
        for (int i = 0; i < 4000; i++) begin
            bus.phy_ready = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 199) == 0) begin
                r = 4'($urandom_range(0, 15));
                bus.cfg_lanes_disable = r;
            end
            r = 4'hF;
            if ($urandom_range(0, 79) == 0) r[$urandom_range(0, 3)] = 1'b0;
            bus.lane_cgs_ready = r;
            bus.lane_buffer_ready_n = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if (i == 2000) begin
                #2 reset = 1'b1;
                model_reset();
                #2 compare_all();
                #2 reset = 1'b0;
            end
            tick();
        end

        // Lane 1 never ready.
        #2 reset = 1'b1;
        model_reset();
        #2 compare_all();
        #2 reset = 1'b0;
        bus.cfg_lanes_disable = 4'h0;
        bus.lane_cgs_ready = 4'b1101;
        bus.phy_ready = 1'b1;
        run_until(MCgs, 10, "enter_cgs_lane1_stuck");
`ifdef JESD204_RX_SEQ_TIMEOUT_EN
        n = 0;
        while (m_state == MCgs && n < 70000) begin tick(); n++; end
        chk("timeout_cycles", 32'(n), 32'd65535);
        chk("timeout_state", 32'(bus.status_state), 32'(MReset));
        chk("timeout_restart", 32'(bus.status_restart_cnt), 32'd1);
`else
        repeat (3000) tick();
        chk("no_timeout_stays_cgs", 32'(bus.status_state), 32'(MCgs));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
